// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux4_scan_ctrl
// Purpose  : Scan controller for a 4:1 single-bit mux. Steps the mux select
//            through the enabled channels in ascending order, holds each select
//            for DWELL cycles, samples the mux output at the end of each dwell
//            and packs the samples into a 4-bit word that is delivered on a
//            valid/ready handshake, either one-shot or continuously.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active-high
//            start      - scan request, honoured only when idle
//            cont       - restart a scan after every handshake when high
//            en_mask    - channel enables (bit i = channel i), latched at start
//            mux_in     - output of the 4:1 mux
//            sel        - mux select
//            word       - assembled word, bit i = sample of channel i
//            word_valid - word holds a complete scan
//            word_ready - downstream accepts word
//            busy       - high from scan start until return to idle
// Params   : DWELL (1..2**CNT_W-1) cycles per select, CNT_W dwell counter width
// Revision : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] en_mask,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_settle = 2'd1;
  localparam logic [1:0] c_hold   = 2'd2;

  // Count value on which the current channel is captured.
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DWELL - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_mask;
  logic [3:0]       r_shadow;
  logic [3:0]       r_word;
  logic             r_valid;
  logic             r_busy;

  logic             w_has_next;
  logic [1:0]       w_next_sel;
  logic [3:0]       w_shadow_upd;

  // Lowest enabled channel of a mask; callers guarantee the mask is non-zero.
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  // Next enabled channel strictly above the current select. Scanning from the
  // top down leaves the lowest such channel as the final assignment.
  always_comb begin
    w_has_next = 1'b0;
    w_next_sel = r_sel;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(r_sel)) && r_mask[i]) begin
        w_has_next = 1'b1;
        w_next_sel = 2'(i);
      end
    end
  end

  // Shadow word with the channel currently being captured merged in; this is
  // also the completed word on the final capture of a scan.
  always_comb begin
    w_shadow_upd        = r_shadow;
    w_shadow_upd[r_sel] = mux_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_idle;
      r_sel    <= 2'd0;
      r_cnt    <= '0;
      r_mask   <= 4'd0;
      r_shadow <= 4'd0;
      r_word   <= 4'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start && (|en_mask)) begin
            r_mask   <= en_mask;
            r_sel    <= f_lowest(en_mask);
            r_cnt    <= '0;
            r_shadow <= 4'd0;
            r_busy   <= 1'b1;
            r_state  <= c_settle;
          end
        end

        c_settle: begin
          if (r_cnt == c_last_cnt) begin
            r_shadow <= w_shadow_upd;
            r_cnt    <= '0;
            if (w_has_next) begin
              r_sel <= w_next_sel;
            end else begin
              // Last channel: sel stays put so it reads the final channel.
              r_word  <= w_shadow_upd;
              r_valid <= 1'b1;
              r_state <= c_hold;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        c_hold: begin
          // word_valid is always high here, so ready alone marks the handshake.
          if (word_ready) begin
            r_valid <= 1'b0;
            if (cont) begin
              r_sel    <= f_lowest(r_mask);
              r_cnt    <= '0;
              r_shadow <= 4'd0;
              r_state  <= c_settle;
            end else begin
              r_busy  <= 1'b0;
              r_state <= c_idle;
            end
          end
        end

        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign word       = r_word;
  assign word_valid = r_valid;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_scan_ctrl
// Purpose  : Self-checking bench for mux4_scan_ctrl. A behavioural 4:1 mux
//            (mux_in = din[sel]) closes the loop around the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_ctrl;

  localparam int DWELL = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] en_mask;
  logic       mux_in;
  logic [1:0] sel;
  logic [3:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic [3:0] din;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] din;
    logic [3:0] mask;
    logic [3:0] exp_word;
    int         k;
  } vec_t;

  vec_t vecs[6];

  mux4_scan_ctrl #(
    .DWELL(DWELL),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .en_mask   (en_mask),
    .mux_in    (mux_in),
    .sel       (sel),
    .word      (word),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy)
  );

  // Behavioural mux4x1
  assign mux_in = din[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-shot scan with start held high throughout (must be ignored while busy)
  // and en_mask scrambled after the start edge (must not affect the scan).
  task automatic run_scan(input vec_t v, input string tag);
    int ch[4];
    int nk;
    nk = 0;
    for (int i = 0; i < 4; i++) begin
      ch[i] = 0;
      if (v.mask[i]) begin
        ch[nk] = i;
        nk++;
      end
    end
    din        = v.din;
    en_mask    = v.mask;
    cont       = 1'b0;
    word_ready = 1'b0;
    start      = 1'b1;
    step();
    en_mask = ~v.mask;
    for (int j = 0; j < v.k * DWELL; j++) begin
      chk({tag, " busy"}, busy, 1);
      chk({tag, " sel"}, sel, ch[j / DWELL]);
      chk({tag, " valid_early"}, word_valid, 0);
      step();
    end
    start = 1'b0;
    chk({tag, " valid"}, word_valid, 1);
    chk({tag, " word"}, word, v.exp_word);
    chk({tag, " sel_hold"}, sel, ch[nk-1]);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk({tag, " valid_after_hs"}, word_valid, 0);
    chk({tag, " busy_after_hs"}, busy, 0);
    chk({tag, " word_kept"}, word, v.exp_word);
    chk({tag, " sel_idle"}, sel, ch[nk-1]);
  endtask

  initial begin
    int n;

    vecs[0] = '{din: 4'b1010, mask: 4'b1111, exp_word: 4'b1010, k: 4};
    vecs[1] = '{din: 4'b1111, mask: 4'b0101, exp_word: 4'b0101, k: 2};
    vecs[2] = '{din: 4'b0110, mask: 4'b1000, exp_word: 4'b0000, k: 1};
    vecs[3] = '{din: 4'b1001, mask: 4'b1001, exp_word: 4'b1001, k: 2};
    vecs[4] = '{din: 4'b0101, mask: 4'b1110, exp_word: 4'b0100, k: 3};
    vecs[5] = '{din: 4'b1111, mask: 4'b0010, exp_word: 4'b0010, k: 1};

    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    en_mask    = 4'd0;
    word_ready = 1'b0;
    din        = 4'd0;

    // Reset state
    step();
    step();
    chk("rst sel", sel, 0);
    chk("rst word", word, 0);
    chk("rst valid", word_valid, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;

    // Start with an empty mask is ignored
    din     = 4'b1111;
    en_mask = 4'b0000;
    start   = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("nomask busy", busy, 0);
    chk("nomask sel", sel, 0);
    chk("nomask valid", word_valid, 0);

    // Table-driven one-shot scans
    for (int t = 0; t < 6; t++) begin
      run_scan(vecs[t], $sformatf("vec%0d", t));
    end

    // Back-pressure in HOLD with start pulsed; mask 0111 -> 3 channels
    din     = 4'b0011;
    en_mask = 4'b0111;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3 * DWELL) step();
    chk("bp valid", word_valid, 1);
    chk("bp word", word, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      din   = 4'(i);
      step();
      chk("bp hold_valid", word_valid, 1);
      chk("bp hold_word", word, 4'b0011);
      chk("bp hold_sel", sel, 2);
      chk("bp hold_busy", busy, 1);
    end
    start      = 1'b0;
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    chk("bp hs_valid", word_valid, 0);
    chk("bp hs_busy", busy, 0);
    step();
    chk("bp idle_busy", busy, 0);

    // Continuous mode: words every 4*DWELL+1 cycles, din changed per scan
    din        = 4'b0110;
    en_mask    = 4'b1111;
    cont       = 1'b1;
    word_ready = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!word_valid && n < 30) begin
      step();
      n++;
    end
    chk("cont first_latency", n, 8);
    chk("cont word_a", word, 4'b0110);
    din = 4'b1001;
    n = 0;
    do begin
      step();
      n++;
    end while (!word_valid && n < 30);
    chk("cont period_b", n, 9);
    chk("cont word_b", word, 4'b1001);
    din = 4'b1101;
    n = 0;
    do begin
      step();
      n++;
    end while (!word_valid && n < 30);
    chk("cont period_c", n, 9);
    chk("cont word_c", word, 4'b1101);
    cont = 1'b0;
    step();
    word_ready = 1'b0;
    chk("cont stop_valid", word_valid, 0);
    chk("cont stop_busy", busy, 0);
    chk("cont stop_word", word, 4'b1101);

    // Reset in the middle of a scan
    din     = 4'b1010;
    en_mask = 4'b1111;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midrst pre_sel", sel, 1);
    rst = 1'b1;
    step();
    chk("midrst sel", sel, 0);
    chk("midrst word", word, 0);
    chk("midrst valid", word_valid, 0);
    chk("midrst busy", busy, 0);
    rst = 1'b0;
    run_scan(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
